// File: rtl/pc_gen_if.sv
// Fetch-side bus of the PC generator: redirect/exception/RAS controls in,
// fetch PC, EPC and return-address-stack status out.
interface pc_gen_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic             stall;
  logic             redir_valid;
  logic [WIDTH-1:0] redir_target;
  logic             exc_req;
  logic [WIDTH-1:0] exc_pc;
  logic             eret;
  logic             ras_push;
  logic [WIDTH-1:0] ras_wdata;
  logic             ras_pop;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] epc;
  logic             addr_err;
  logic [WIDTH-1:0] ras_top;
  logic             ras_valid;
  logic [CW-1:0]    ras_count;

  modport master (
    output stall, redir_valid, redir_target, exc_req, exc_pc, eret,
           ras_push, ras_wdata, ras_pop,
    input  pc, pc_plus4, epc, addr_err, ras_top, ras_valid, ras_count
  );

  modport slave (
    input  stall, redir_valid, redir_target, exc_req, exc_pc, eret,
           ras_push, ras_wdata, ras_pop,
    output pc, pc_plus4, epc, addr_err, ras_top, ras_valid, ras_count
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator with exception/EPC handling, misaligned-redirect trap
// and a circular return-address stack that overwrites its oldest entry.
module pc_gen #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
  parameter int               RAS_DEPTH  = 4
) (
  input logic     clk,
  input logic     reset,
  pc_gen_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_addr_err;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_stack [RAS_DEPTH];

  logic             w_mis;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_replace;
  logic             w_pop;
  logic [PW-1:0]    w_top_idx;

  // A redirect squashed by stall is never examined for alignment.
  assign w_mis     = bus.redir_valid & ~bus.stall & ~bus.exc_req &
                     (bus.redir_target[1:0] != 2'b00);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(RAS_DEPTH));
  assign w_push    = bus.ras_push & (~bus.ras_pop | w_empty);
  assign w_replace = bus.ras_push & bus.ras_pop & ~w_empty;
  assign w_pop     = bus.ras_pop & ~bus.ras_push & ~w_empty;
  assign w_top_idx = r_ptr - PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_epc      <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_mis;
      if (bus.exc_req) begin
        r_pc  <= EXC_VECTOR;
        r_epc <= bus.exc_pc;
      end else if (w_mis) begin
        r_pc  <= EXC_VECTOR;
        r_epc <= bus.redir_target;
      end else if (bus.eret) begin
        r_pc <= r_epc;
      end else if (bus.stall) begin
        r_pc <= r_pc;
      end else if (bus.redir_valid) begin
        r_pc <= bus.redir_target;
      end else begin
        r_pc <= r_pc + WIDTH'(4);
      end
    end
  end

  // r_ptr is the next free slot; the top entry sits just below it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!w_full) r_count <= r_count + CW'(1);
    end else if (w_pop) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_push)         r_stack[r_ptr]     <= bus.ras_wdata;
      else if (w_replace) r_stack[w_top_idx] <= bus.ras_wdata;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.pc_plus4  = r_pc + WIDTH'(4);
  assign bus.epc       = r_epc;
  assign bus.addr_err  = r_addr_err;
  assign bus.ras_top   = w_empty ? '0 : r_stack[w_top_idx];
  assign bus.ras_valid = ~w_empty;
  assign bus.ras_count = r_count;
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations,
// then randomized traffic against a queue-based behavioural model.
module tb_pc_gen;
  localparam int               WIDTH = 32;
  localparam int               DEPTH = 4;
  localparam logic [WIDTH-1:0] RPC   = 32'h0000_3000;
  localparam logic [WIDTH-1:0] EVEC  = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_epc;
  logic             m_ae;
  logic [WIDTH-1:0] m_q [$];

  pc_gen_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) ifc ();

  pc_gen #(
    .WIDTH(WIDTH), .RESET_PC(RPC), .EXC_VECTOR(EVEC), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = RPC;
    m_epc = '0;
    m_ae  = 1'b0;
    m_q.delete();
  endtask

  task automatic cmp_all();
    logic [WIDTH-1:0] top;
    top = (m_q.size() != 0) ? m_q[m_q.size()-1] : '0;
    chk("pc",        ifc.pc, m_pc);
    chk("pc_plus4",  ifc.pc_plus4, m_pc + 32'd4);
    chk("epc",       ifc.epc, m_epc);
    chk("addr_err",  32'(ifc.addr_err), 32'(m_ae));
    chk("ras_count", 32'(ifc.ras_count), 32'(m_q.size()));
    chk("ras_valid", 32'(ifc.ras_valid), 32'(m_q.size() != 0));
    chk("ras_top",   ifc.ras_top, top);
  endtask

  task automatic step(input bit st, input bit rv, input logic [WIDTH-1:0] tgt,
                      input bit ex, input logic [WIDTH-1:0] xpc, input bit er,
                      input bit pu, input logic [WIDTH-1:0] wd, input bit po);
    bit mis;
    ifc.stall = st;   ifc.redir_valid = rv; ifc.redir_target = tgt;
    ifc.exc_req = ex; ifc.exc_pc = xpc;     ifc.eret = er;
    ifc.ras_push = pu; ifc.ras_wdata = wd;  ifc.ras_pop = po;
    @(posedge clk);
    mis = rv && !st && !ex && (tgt[1:0] != 2'b00);
    if (ex)            begin m_pc = EVEC; m_epc = xpc; end
    else if (mis)      begin m_pc = EVEC; m_epc = tgt; end
    else if (er)       m_pc = m_epc;
    else if (st)       m_pc = m_pc;
    else if (rv)       m_pc = tgt;
    else               m_pc = m_pc + 32'd4;
    m_ae = mis;
    if (pu && po && m_q.size() != 0) m_q[m_q.size()-1] = wd;
    else if (pu) begin
      m_q.push_back(wd);
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
    end else if (po && m_q.size() != 0) void'(m_q.pop_back());
    #1;
    cmp_all();
  endtask

  task automatic idle();
    step(0, 0, '0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset_pc", ifc.pc, 32'h0000_3000);
    cmp_all();
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ifc.stall = 0; ifc.redir_valid = 0; ifc.redir_target = '0;
    ifc.exc_req = 0; ifc.exc_pc = '0; ifc.eret = 0;
    ifc.ras_push = 0; ifc.ras_wdata = '0; ifc.ras_pop = 0;
    model_reset();
    #3;
    chk("reset_pc", ifc.pc, 32'h0000_3000);
    cmp_all();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release_pc", ifc.pc, 32'h0000_3000);

    idle(); chk("seq1", ifc.pc, 32'h0000_3004);
    idle(); chk("seq2", ifc.pc, 32'h0000_3008);
    idle(); chk("seq3", ifc.pc, 32'h0000_300C);
    chk("seq_epc", ifc.epc, 32'h0);

    step(1, 1, 32'h3100, 0, '0, 0, 0, '0, 0); chk("stall1", ifc.pc, 32'h0000_300C);
    step(1, 1, 32'h3100, 0, '0, 0, 0, '0, 0); chk("stall2", ifc.pc, 32'h0000_300C);
    step(0, 1, 32'h3100, 0, '0, 0, 0, '0, 0); chk("redir", ifc.pc, 32'h0000_3100);
    step(1, 1, 32'h3101, 0, '0, 0, 0, '0, 0); chk("stall_mis_ignored", 32'(ifc.addr_err), 32'h0);

    step(0, 1, 32'h3200, 1, 32'h3010, 0, 0, '0, 0);
    chk("exc_pc", ifc.pc, 32'h0000_4180);
    chk("exc_epc", ifc.epc, 32'h0000_3010);
    step(1, 0, '0, 0, '0, 1, 0, '0, 0); chk("eret", ifc.pc, 32'h0000_3010);

    step(0, 1, 32'h3102, 0, '0, 0, 0, '0, 0);
    chk("mis_pc", ifc.pc, 32'h0000_4180);
    chk("mis_epc", ifc.epc, 32'h0000_3102);
    chk("mis_ae", 32'(ifc.addr_err), 32'h1);
    idle(); chk("mis_ae_drop", 32'(ifc.addr_err), 32'h0);

    for (int i = 0; i < 5; i++) step(0, 0, '0, 0, '0, 0, 1, 32'hA0 + 32'(i), 0);
    chk("ras_full_count", 32'(ifc.ras_count), 32'd4);
    chk("ras_full_top", ifc.ras_top, 32'hA4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 0, '0, 0, 0, '0, 1);
      chk("ras_pop_top", ifc.ras_top, 32'hA3 - 32'(i));
    end
    step(0, 0, '0, 0, '0, 0, 0, '0, 1);
    chk("ras_empty_valid", 32'(ifc.ras_valid), 32'h0);
    chk("ras_empty_top", ifc.ras_top, 32'h0);
    step(0, 0, '0, 0, '0, 0, 0, '0, 1);
    chk("ras_underflow_cnt", 32'(ifc.ras_count), 32'h0);
    step(0, 0, '0, 0, '0, 0, 1, 32'hBEEF, 1);
    chk("ras_pp_empty", ifc.ras_top, 32'hBEEF);
    step(0, 0, '0, 0, '0, 0, 1, 32'hCAFE, 1);
    chk("ras_pp_replace", ifc.ras_top, 32'hCAFE);
    chk("ras_pp_count", 32'(ifc.ras_count), 32'h1);

    step(0, 1, 32'hFFFF_FFFC, 0, '0, 0, 0, '0, 0);
    idle(); chk("wrap", ifc.pc, 32'h0);
    reset_pulse();
    chk("reset_ras_top", ifc.ras_top, 32'h0);
    idle(); chk("post_reset", ifc.pc, 32'h0000_3004);

    for (int i = 0; i < 600; i++) begin
      logic [WIDTH-1:0] tgt;
      tgt = $urandom;
      if ($urandom_range(0, 5) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 79) == 0) reset_pulse();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, tgt,
           $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 11) == 0,
           $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, 32: PC and address width in bits (>= 8).
REQ-002 Parameter RESET_PC, 32'h0000_3000: PC value at reset.
REQ-003 Parameter EXC_VECTOR, 32'h0000_4180: exception handler entry address.
REQ-004 Parameter RAS_DEPTH, 4: return-address-stack entries (power of two, 2..16).
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately when asserted.
REQ-007 stall  in  1  hold PC (fetch freeze).
REQ-008 redir_valid  in  1  resolved branch/jump taken this cycle.
REQ-009 redir_target  in  WIDTH  redirect destination.
REQ-010 exc_req  in  1  exception request.
REQ-011 exc_pc  in  WIDTH  faulting PC to save in EPC.
REQ-012 eret  in  1  return from exception.
REQ-013 ras_push  in  1  call executed; push ras_wdata.
REQ-014 ras_wdata  in  WIDTH  return address to push.
REQ-015 ras_pop  in  1  return executed; pop top.
REQ-016 pc  out  WIDTH  current fetch PC (registered).
REQ-017 pc_plus4  out  WIDTH  pc + 4, combinational, modulo 2^WIDTH.
REQ-018 epc  out  WIDTH  saved exception PC (registered).
REQ-019 addr_err  out  1  one-cycle registered pulse: misaligned redirect detected.
REQ-020 ras_top  out  WIDTH  top-of-stack value; 0 when empty.
REQ-021 ras_valid  out  1  stack non-empty.
REQ-022 ras_count  out  clog2(RAS_DEPTH)+1  number of valid entries.

Function
REQ-023 Next-PC priority per edge SHALL be: exc_req > misaligned redirect > eret > stall > redir_valid > sequential.
REQ-024 exc_req SHALL load pc <= EXC_VECTOR and epc <= exc_pc, regardless of stall.
REQ-025 Redirect with redir_valid=1, stall=0, redir_target[1:0]!=0 and no exc_req SHALL load pc <= EXC_VECTOR, epc <= redir_target, addr_err=1 next cycle.
REQ-026 eret (no exc_req, no misaligned redirect) SHALL load pc <= epc, regardless of stall; epc unchanged.
REQ-027 stall=1 with no exc_req/eret SHALL hold pc; redir_valid in that cycle SHALL be ignored and not checked for alignment.
REQ-028 Aligned redirect SHALL load pc <= redir_target with one-edge latency.
REQ-029 Otherwise pc <= pc + 4; 2^WIDTH-4 wraps to 0 with no flag.
REQ-030 addr_err SHALL be high exactly one cycle per misaligned redirect, 0 otherwise.
REQ-031 RAS SHALL be a circular buffer with pointer and count; push writes ras_wdata at top, count increments saturating at RAS_DEPTH.
REQ-032 Push when full SHALL overwrite the oldest entry (pointer wraps); count stays RAS_DEPTH.
REQ-033 Pop when empty SHALL be ignored; ras_valid stays 0, no error.
REQ-034 Simultaneous push and pop SHALL replace top with ras_wdata; count unchanged (if empty, behaves as push).
REQ-035 RAS updates SHALL occur independent of stall; exc_req SHALL not alter RAS.
REQ-036 ras_top SHALL reflect the post-edge state combinationally from stack storage.

Reset
REQ-037 While reset=1: pc=RESET_PC, epc=0, addr_err=0, ras_count=0, ras_valid=0, ras_top=0, pointer=0; asynchronous, effective without a clock edge.
REQ-038 Reset asserted mid-operation SHALL discard any pending redirect, exception or stack operation; first edge after deassert gives pc=RESET_PC+4 if no other input active.
REQ-039 Stack storage contents need not be cleared; ras_top SHALL read 0 while count=0.

Verification
REQ-040 Reset release, 3 idle edges -> pc 0x3000, 0x3004, 0x3008, 0x300C; epc=0.
REQ-041 stall=1 with redir_valid=1, target 0x3100 for 2 edges -> pc held; stall drops, redirect held -> pc=0x3100 next edge.
REQ-042 exc_req with exc_pc=0x3010 plus redir_valid same cycle -> pc=0x4180, epc=0x3010; then eret -> pc=0x3010.
REQ-043 Redirect to 0x3102 -> pc=0x4180, epc=0x3102, addr_err high one cycle only.
REQ-044 RAS_DEPTH=4: push A,B,C,D,E -> count=4, top=E; 4 pops -> tops D,C,B then empty; further pop -> ras_valid=0, top=0.
REQ-045 pc=0xFFFF_FFFC idle edge -> pc=0; async reset pulse between edges -> pc=0x3000 immediately.
